serpent_round_ctrl: RTL and testbench



---
 rtl/serpent_round_ctrl.sv | 142 ++++++++++++++
 tb/tb_serpent_round_ctrl.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/serpent_round_ctrl.sv
// Serpent round sequencer: time-shares one external S-box layer over 32 rounds, one round per clock.
// Optional abort input enabled by defining SERPENT_CTRL_ABORT_EN.
module serpent_round_ctrl #(
    parameter int unsigned ROUNDS = 32,
    parameter int unsigned KEY_AW = 6
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
`ifdef SERPENT_CTRL_ABORT_EN
    input  logic              i_abort,
`endif
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [127:0]      i_block,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [127:0]      o_data,
    output logic [KEY_AW-1:0] o_rk_addr,
    input  logic [127:0]      i_rk_data,
    output logic [127:0]      o_sbox_data,
    output logic [2:0]        o_sbox_index,
    input  logic [127:0]      i_sbox_data,
    output logic              o_busy
);

    localparam int unsigned RW = $clog2(ROUNDS);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ROUND = 2'd1,
        S_FINAL = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t          r_state;
    logic [127:0]    r_st;
    logic [RW-1:0]   r_round;
    logic            r_ready;
    logic            r_valid;
    logic            r_busy;
    logic [127:0]    r_data;
    logic            w_abort;
    logic            w_last;

`ifdef SERPENT_CTRL_ABORT_EN
    assign w_abort = i_abort;
`else
    assign w_abort = 1'b0;
`endif

    assign w_last = (r_round == RW'(ROUNDS - 1));

    function automatic logic [31:0] f_rotl(input logic [31:0] x, input int unsigned n);
        return (x << n) | (x >> (32 - n));
    endfunction

    // Serpent linear transform on {X3,X2,X1,X0}
    function automatic logic [127:0] f_lt(input logic [127:0] v);
        logic [31:0] x0, x1, x2, x3;
        x0 = v[31:0];
        x1 = v[63:32];
        x2 = v[95:64];
        x3 = v[127:96];
        x0 = f_rotl(x0, 13);
        x2 = f_rotl(x2, 3);
        x1 = x1 ^ x0 ^ x2;
        x3 = x3 ^ x2 ^ (x0 << 3);
        x1 = f_rotl(x1, 1);
        x3 = f_rotl(x3, 7);
        x0 = x0 ^ x1 ^ x3;
        x2 = x2 ^ x3 ^ (x1 << 7);
        x0 = f_rotl(x0, 5);
        x2 = f_rotl(x2, 22);
        return {x3, x2, x1, x0};
    endfunction

    // Key-store and S-box buses are decoded from state so the key read lands in the same cycle
    assign o_rk_addr    = (r_state == S_ROUND) ? KEY_AW'(r_round) :
                          (r_state == S_FINAL) ? KEY_AW'(ROUNDS)  : '0;
    assign o_sbox_index = (r_state == S_ROUND) ? r_round[2:0] : 3'd0;
    assign o_sbox_data  = (r_state == S_ROUND) ? (r_st ^ i_rk_data) : '0;

    assign o_ready = r_ready;
    assign o_valid = r_valid;
    assign o_busy  = r_busy;
    assign o_data  = r_data;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
            r_st    <= '0;
            r_round <= '0;
            r_ready <= 1'b1;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_data  <= '0;
        end else if (w_abort && (r_state != S_IDLE)) begin
            // Abort drops the block but leaves st and the last ciphertext untouched
            r_state <= S_IDLE;
            r_ready <= 1'b1;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_valid) begin
                        r_st    <= i_block;
                        r_round <= '0;
                        r_ready <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= S_ROUND;
                    end
                end
                S_ROUND: begin
                    if (w_last) begin
                        r_st    <= i_sbox_data;
                        r_state <= S_FINAL;
                    end else begin
                        r_st    <= f_lt(i_sbox_data);
                        r_round <= r_round + RW'(1);
                    end
                end
                S_FINAL: begin
                    r_st    <= r_st ^ i_rk_data;
                    r_data  <= r_st ^ i_rk_data;
                    r_valid <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_DONE;
                end
                S_DONE: begin
                    if (i_ready) begin
                        r_valid <= 1'b0;
                        r_ready <= 1'b1;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serpent_round_ctrl.sv
// Directed/random bench for serpent_round_ctrl with a behavioural Serpent model and S-box layer.
module tb_serpent_round_ctrl;

    logic         i_clk = 1'b0;
    logic         i_rst_n = 1'b0;
    logic         i_valid = 1'b0;
    logic         i_ready = 1'b1;
    logic [127:0] i_block = '0;
`ifdef SERPENT_CTRL_ABORT_EN
    logic         i_abort = 1'b0;
`endif
    logic         o_ready, o_valid, o_busy;
    logic [127:0] o_data, o_sbox_data, i_rk_data, i_sbox_data;
    logic [5:0]   o_rk_addr;
    logic [2:0]   o_sbox_index;

    logic [127:0] keys [0:32];
    int           n_chk = 0;
    int           n_pass = 0;
    int           n_vld = 0;
    int           cyc = 0;
    int           acc_q [$];

    serpent_round_ctrl dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
`ifdef SERPENT_CTRL_ABORT_EN
        .i_abort      (i_abort),
`endif
        .i_valid      (i_valid),
        .o_ready      (o_ready),
        .i_block      (i_block),
        .o_valid      (o_valid),
        .i_ready      (i_ready),
        .o_data       (o_data),
        .o_rk_addr    (o_rk_addr),
        .i_rk_data    (i_rk_data),
        .o_sbox_data  (o_sbox_data),
        .o_sbox_index (o_sbox_index),
        .i_sbox_data  (i_sbox_data),
        .o_busy       (o_busy)
    );

    always #5 i_clk = ~i_clk;

    // Serpent S-boxes, entries listed for inputs 0..15 left to right
    function automatic logic [63:0] sbox_tab(input int idx);
        case (idx)
            0: return 64'h38F1A65BED42709C;
            1: return 64'hFC27905A1BE86D34;
            2: return 64'h86793CAFD1E40B52;
            3: return 64'h0FB8C963D124A75E;
            4: return 64'h1F83C0B6254A9E7D;
            5: return 64'hF52B4A9C03E8D671;
            6: return 64'h72C5846BE91FD3A0;
            default: return 64'h1DF0E82B74CA9356;
        endcase
    endfunction

    function automatic logic [127:0] sbox_layer(input logic [127:0] d, input int idx);
        logic [63:0]  tab;
        logic [127:0] o;
        int           v;
        tab = sbox_tab(idx);
        o   = '0;
        for (int n = 0; n < 32; n++) begin
            v = int'(d[4*n +: 4]);
            o[4*n +: 4] = tab[63 - 4*v -: 4];
        end
        return o;
    endfunction

    function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
        return (x << n) | (x >> (32 - n));
    endfunction

    function automatic logic [127:0] lt_ref(input logic [127:0] v);
        logic [31:0] w [4];
        for (int i = 0; i < 4; i++) w[i] = v[32*i +: 32];
        w[0] = rotl(w[0], 13);
        w[2] = rotl(w[2], 3);
        w[1] ^= w[0] ^ w[2];
        w[3] ^= w[2] ^ (w[0] << 3);
        w[1] = rotl(w[1], 1);
        w[3] = rotl(w[3], 7);
        w[0] ^= w[1] ^ w[3];
        w[2] ^= w[3] ^ (w[1] << 7);
        w[0] = rotl(w[0], 5);
        w[2] = rotl(w[2], 22);
        return {w[3], w[2], w[1], w[0]};
    endfunction

    function automatic logic [127:0] model(input logic [127:0] blk);
        logic [127:0] s;
        s = blk;
        for (int r = 0; r < 32; r++) begin
            s = sbox_layer(s ^ keys[r], r % 8);
            if (r < 31) s = lt_ref(s);
        end
        return s ^ keys[32];
    endfunction

    assign i_rk_data   = (o_rk_addr <= 6'd32) ? keys[o_rk_addr] : '0;
    assign i_sbox_data = sbox_layer(o_sbox_data, int'(o_sbox_index));

    always @(posedge i_clk) begin
        cyc++;
        if (i_rst_n && o_ready && i_valid) acc_q.push_back(cyc);
    end

    always @(negedge i_clk) if (o_valid === 1'b1) n_vld++;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    function automatic logic [127:0] stv(input bit rdy, input bit vld, input bit bsy,
                                         input int addr, input int idx);
        return 128'({rdy, vld, bsy, 6'(addr), 3'(idx)});
    endfunction

    function automatic logic [127:0] obs_st();
        return 128'({o_ready, o_valid, o_busy, o_rk_addr, o_sbox_index});
    endfunction

    task automatic rand_keys();
        for (int i = 0; i < 33; i++) keys[i] = {$urandom, $urandom, $urandom, $urandom};
    endtask

    // Called at a negedge in IDLE; returns at the negedge of round 0
    task automatic accept_block(input logic [127:0] blk, input bit hold);
        chk("ready_before_accept", 128'(o_ready), 128'(1));
        i_block = blk;
        i_valid = 1'b1;
        @(negedge i_clk);
        if (!hold) i_valid = 1'b0;
        chk("sbox_data_round0", o_sbox_data, blk ^ keys[0]);
    endtask

    // Checks cycles k = from .. to-1 after accept; returns at negedge of cycle k = to
    task automatic step_rounds(input int from, input int to);
        for (int k = from; k < to; k++) begin
            if (k < 32) chk($sformatf("status_round%0d", k), obs_st(), stv(0, 0, 1, k, k % 8));
            else        chk("status_final", obs_st(), stv(0, 0, 1, 32, 0));
            @(negedge i_clk);
        end
    endtask

    task automatic run_block(input logic [127:0] blk, input int bp, input bit hold,
                             input logic [127:0] next_blk, output logic [127:0] exp);
        exp = model(blk);
        accept_block(blk, hold);
        step_rounds(0, 33);
        chk("done_status", obs_st(), stv(0, 1, 0, 0, 0));
        chk("done_data", o_data, exp);
        if (hold) i_block = next_blk;
        if (bp > 0) begin
            i_ready = 1'b0;
            for (int c = 0; c < bp; c++) begin
                @(negedge i_clk);
                chk("bp_valid_data", {127'(0), o_valid} ^ o_data, {127'(0), 1'b1} ^ exp);
            end
            i_ready = 1'b1;
        end
        @(negedge i_clk);
        chk("idle_after_handshake", obs_st(), stv(1, 0, 0, 0, 0));
        chk("data_held_in_idle", o_data, exp);
    endtask

    initial begin
        logic [127:0] e1, e2, last_out, b1, b2;
        int v0;

        // Reset held for 3 cycles
        for (int i = 0; i < 33; i++) keys[i] = '0;
        i_rst_n = 1'b0;
        repeat (3) @(negedge i_clk);
        i_rst_n = 1'b1;
        chk("reset_status", obs_st(), stv(1, 0, 0, 0, 0));
        chk("reset_data", o_data, '0);
        chk("reset_sbox_data", o_sbox_data, '0);

        // Zero key, zero block
        run_block('0, 0, 1'b0, '0, e1);

        // Random block with backpressure
        rand_keys();
        run_block({$urandom, $urandom, $urandom, $urandom}, 10, 1'b0, '0, e1);

        // Back-to-back with i_valid held high
        rand_keys();
        b1 = {$urandom, $urandom, $urandom, $urandom};
        b2 = {$urandom, $urandom, $urandom, $urandom};
        acc_q.delete();
        run_block(b1, 0, 1'b1, b2, e1);
        run_block(b2, 0, 1'b1, b2, e2);
        i_valid = 1'b0;
        chk("b2b_accept_count", 128'(acc_q.size()), 128'(2));
        if (acc_q.size() == 2) chk("b2b_accept_spacing", 128'(acc_q[1] - acc_q[0]), 128'(35));
        chk("b2b_outputs_distinct", 128'(e1 != e2), 128'(1));
        last_out = e2;

        // Reset at round 15
        rand_keys();
        accept_block({$urandom, $urandom, $urandom, $urandom}, 1'b0);
        step_rounds(0, 15);
        i_rst_n = 1'b0;
        @(negedge i_clk);
        i_rst_n = 1'b1;
        chk("midreset_status", obs_st(), stv(1, 0, 0, 0, 0));
        chk("midreset_data", o_data, '0);
        chk("midreset_sbox_data", o_sbox_data, '0);
        v0 = n_vld;
        repeat (40) @(negedge i_clk);
        chk("midreset_no_valid", 128'(n_vld - v0), 128'(0));
        run_block({$urandom, $urandom, $urandom, $urandom}, 0, 1'b0, '0, last_out);

`ifdef SERPENT_CTRL_ABORT_EN
        // Abort at round 20
        rand_keys();
        accept_block({$urandom, $urandom, $urandom, $urandom}, 1'b0);
        step_rounds(0, 20);
        i_abort = 1'b1;
        @(negedge i_clk);
        i_abort = 1'b0;
        chk("abort_status", obs_st(), stv(1, 0, 0, 0, 0));
        chk("abort_data_kept", o_data, last_out);
        v0 = n_vld;
        repeat (40) @(negedge i_clk);
        chk("abort_no_valid", 128'(n_vld - v0), 128'(0));
        run_block({$urandom, $urandom, $urandom, $urandom}, 3, 1'b0, '0, last_out);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
